// File: rtl/uart_regif_v2_pkg.sv
// Shared register map, FSM state type and byte-lane merge helper for the UART register interface.
package apb_uart_pkg;

  localparam int unsigned REG_CTRL_ADDR          = 'h00;
  localparam int unsigned REG_CLK_DIV_ADDR       = 'h04;
  localparam int unsigned REG_CFG_ADDR           = 'h08;
  localparam int unsigned REG_TX_FIFO_COUNT_ADDR = 'h0C;
  localparam int unsigned REG_RX_FIFO_COUNT_ADDR = 'h10;
  localparam int unsigned REG_TX_DATA_ADDR       = 'h14;
  localparam int unsigned REG_RX_DATA_ADDR       = 'h18;
  localparam int unsigned REG_INTR_EN_ADDR       = 'h1C;
  localparam int unsigned REG_INTR_STAT_ADDR     = 'h20;

  // Widest bus the merge helper supports; callers cast in and out of this width.
  localparam int unsigned MERGE_MAX_W    = 256;
  localparam int unsigned MERGE_MAX_STRB = MERGE_MAX_W / 8;

  typedef enum logic {IDLE, WAIT} regif_state_e;

  function automatic logic [MERGE_MAX_W-1:0] strb_merge(
    input logic [MERGE_MAX_W-1:0]    old_val,
    input logic [MERGE_MAX_W-1:0]    new_val,
    input logic [MERGE_MAX_STRB-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(MERGE_MAX_STRB); i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_regif_v2_if.sv
// Memory-interface bus between the APB bridge (master) and the UART register block (slave).
interface uart_regif_v2_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    mreq_i;
  logic [ADDR_WIDTH-1:0]   maddr_i;
  logic                    mwe_i;
  logic [DATA_WIDTH-1:0]   mwdata_i;
  logic [DATA_WIDTH/8-1:0] mstrb_i;
  logic                    mack_o;
  logic [DATA_WIDTH-1:0]   mrdata_o;
  logic                    mresp_o;

  modport master (
    output mreq_i, maddr_i, mwe_i, mwdata_i, mstrb_i,
    input  mack_o, mrdata_o, mresp_o
  );

  modport slave (
    input  mreq_i, maddr_i, mwe_i, mwdata_i, mstrb_i,
    output mack_o, mrdata_o, mresp_o
  );
endinterface

// File: rtl/uart_regif_v2_intr.sv
// Interrupt enable/status bank: sticky status bits set by event pulses, write-1-to-clear, set wins.
module uart_intr_bank
  import apb_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INTR   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_INTR-1:0]     intr_event,
  input  logic                    en_we,
  input  logic                    stat_we,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [NUM_INTR-1:0]     intr_en,
  output logic [NUM_INTR-1:0]     intr_stat,
  output logic                    intr
);

  logic [NUM_INTR-1:0] clear_mask;

  // Only ones on strobed lanes clear a bit.
  assign clear_mask = stat_we
    ? NUM_INTR'(strb_merge('0, MERGE_MAX_W'(wdata), MERGE_MAX_STRB'(strb)))
    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_en   <= '0;
      intr_stat <= '0;
    end else begin
      if (en_we) begin
        intr_en <= NUM_INTR'(strb_merge(MERGE_MAX_W'(intr_en), MERGE_MAX_W'(wdata),
                                        MERGE_MAX_STRB'(strb)));
      end
      intr_stat <= (intr_stat & ~clear_mask) | intr_event;
    end
  end

  assign intr = |(intr_stat & intr_en);

endmodule

// File: rtl/uart_regif_v2.sv
// UART register interface with byte-strobed writes and bounded wait states on TX_DATA/RX_DATA.
// Wait states are built only when UART_REGIF_STALL_EN is defined; otherwise stalls error at once.
module uart_regif_v2
  import apb_uart_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = 6,
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter int unsigned          NUM_INTR     = 8,
  parameter int unsigned          WAIT_TIMEOUT = 16,
  parameter logic [DATA_WIDTH-1:0] CLK_DIV_RST = 'h2580
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  uart_regif_v2_if.slave        bus,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] clk_div_o,
  output logic [DATA_WIDTH-1:0] cfg_o,
  input  logic [DATA_WIDTH-1:0] tx_fifo_count_i,
  input  logic [DATA_WIDTH-1:0] rx_fifo_count_i,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  tx_data_valid_o,
  input  logic                  tx_data_ready_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_data_valid_i,
  output logic                  rx_data_ready_o,
  input  logic [NUM_INTR-1:0]   intr_event_i,
  output logic [NUM_INTR-1:0]   intr_en_o,
  output logic                  intr_o
);

`ifdef UART_REGIF_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  regif_state_e          state, next_state;
  logic [CNT_W-1:0]      cnt, next_cnt;
  logic                  sel_ctrl, sel_clk_div, sel_cfg, sel_tx_cnt, sel_rx_cnt;
  logic                  sel_tx_data, sel_rx_data, sel_intr_en, sel_intr_stat;
  logic                  mapped, dir_err, strb_err, busy_err, req_err;
  logic                  is_tx_wr, is_rx_rd, stream_ok;
  logic                  ack, resp, push, pop, reg_we;
  logic [DATA_WIDTH-1:0] ctrl_q, clk_div_q, cfg_q, rd_mux;
  logic [NUM_INTR-1:0]   intr_stat;

  always_comb begin
    sel_ctrl      = bus.maddr_i == ADDR_WIDTH'(REG_CTRL_ADDR);
    sel_clk_div   = bus.maddr_i == ADDR_WIDTH'(REG_CLK_DIV_ADDR);
    sel_cfg       = bus.maddr_i == ADDR_WIDTH'(REG_CFG_ADDR);
    sel_tx_cnt    = bus.maddr_i == ADDR_WIDTH'(REG_TX_FIFO_COUNT_ADDR);
    sel_rx_cnt    = bus.maddr_i == ADDR_WIDTH'(REG_RX_FIFO_COUNT_ADDR);
    sel_tx_data   = bus.maddr_i == ADDR_WIDTH'(REG_TX_DATA_ADDR);
    sel_rx_data   = bus.maddr_i == ADDR_WIDTH'(REG_RX_DATA_ADDR);
    sel_intr_en   = bus.maddr_i == ADDR_WIDTH'(REG_INTR_EN_ADDR);
    sel_intr_stat = bus.maddr_i == ADDR_WIDTH'(REG_INTR_STAT_ADDR);
    mapped   = sel_ctrl | sel_clk_div | sel_cfg | sel_tx_cnt | sel_rx_cnt |
               sel_tx_data | sel_rx_data | sel_intr_en | sel_intr_stat;
    dir_err  = bus.mwe_i ? (sel_tx_cnt | sel_rx_cnt | sel_rx_data) : sel_tx_data;
    strb_err = bus.mwe_i && (bus.mstrb_i == '0);
    // Baud/frame settings may only change while both FIFOs are drained.
    busy_err = bus.mwe_i && (sel_clk_div || sel_cfg) &&
               ((tx_fifo_count_i != '0) || (rx_fifo_count_i != '0));
    req_err   = !mapped || dir_err || strb_err || busy_err;
    is_tx_wr  = sel_tx_data && bus.mwe_i;
    is_rx_rd  = sel_rx_data && !bus.mwe_i;
    stream_ok = is_tx_wr ? tx_data_ready_i : rx_data_valid_i;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    ack        = 1'b0;
    resp       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    reg_we     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mreq_i) begin
          if (req_err) begin
            ack  = 1'b1;
            resp = 1'b1;
          end else if ((is_tx_wr || is_rx_rd) && !stream_ok) begin
            if (STALL_EN) begin
              next_state = WAIT;
              next_cnt   = '0;
            end else begin
              ack  = 1'b1;
              resp = 1'b1;
            end
          end else begin
            ack    = 1'b1;
            reg_we = bus.mwe_i && !is_tx_wr;
            push   = is_tx_wr;
            pop    = is_rx_rd;
          end
        end
      end
      WAIT: begin
        if (!bus.mreq_i) begin
          next_state = IDLE;
        end else if (stream_ok) begin
          ack        = 1'b1;
          push       = is_tx_wr;
          pop        = is_rx_rd;
          next_state = IDLE;
        end else if (cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
          ack        = 1'b1;
          resp       = 1'b1;
          next_state = IDLE;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ctrl_q    <= '0;
      clk_div_q <= CLK_DIV_RST;
      cfg_q     <= '0;
    end else if (reg_we) begin
      if (sel_ctrl)
        ctrl_q <= DATA_WIDTH'(strb_merge(MERGE_MAX_W'(ctrl_q), MERGE_MAX_W'(bus.mwdata_i),
                                         MERGE_MAX_STRB'(bus.mstrb_i)));
      if (sel_clk_div)
        clk_div_q <= DATA_WIDTH'(strb_merge(MERGE_MAX_W'(clk_div_q), MERGE_MAX_W'(bus.mwdata_i),
                                            MERGE_MAX_STRB'(bus.mstrb_i)));
      if (sel_cfg)
        cfg_q <= DATA_WIDTH'(strb_merge(MERGE_MAX_W'(cfg_q), MERGE_MAX_W'(bus.mwdata_i),
                                        MERGE_MAX_STRB'(bus.mstrb_i)));
    end
  end

  uart_intr_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INTR   (NUM_INTR)
  ) u_intr_bank (
    .clk        (clk_i),
    .rst_n      (arst_ni),
    .intr_event (intr_event_i),
    .en_we      (reg_we && sel_intr_en),
    .stat_we    (reg_we && sel_intr_stat),
    .wdata      (bus.mwdata_i),
    .strb       (bus.mstrb_i),
    .intr_en    (intr_en_o),
    .intr_stat  (intr_stat),
    .intr       (intr_o)
  );

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)           rd_mux = ctrl_q;
    else if (sel_clk_div)   rd_mux = clk_div_q;
    else if (sel_cfg)       rd_mux = cfg_q;
    else if (sel_tx_cnt)    rd_mux = tx_fifo_count_i;
    else if (sel_rx_cnt)    rd_mux = rx_fifo_count_i;
    else if (sel_rx_data)   rd_mux = rx_data_i;
    else if (sel_intr_en)   rd_mux = DATA_WIDTH'(intr_en_o);
    else if (sel_intr_stat) rd_mux = DATA_WIDTH'(intr_stat);
  end

  assign bus.mack_o      = ack;
  assign bus.mresp_o     = resp;
  assign bus.mrdata_o    = (ack && !resp && !bus.mwe_i) ? rd_mux : '0;
  assign ctrl_o          = ctrl_q;
  assign clk_div_o       = clk_div_q;
  assign cfg_o           = cfg_q;
  assign tx_data_o       = push ? bus.mwdata_i : '0;
  assign tx_data_valid_o = push;
  assign rx_data_ready_o = pop;

endmodule
